// File: rtl/mem_burst_initiator.sv
// Burst sequencer in front of a single-port synchronous memory.
// It accepts a burst command, then either streams write beats into the
// memory or issues reads and returns each word through a response handshake.
// Addresses at or above MEM_DEPTH are never sent to the memory. Those beats
// are dropped (writes) or answered with zero data and rsp_err (reads), and
// they set the sticky error that is reported with done.
module mem_burst_initiator #(
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 8,
   parameter int LEN_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [7:0]        cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              done,
   output logic              err,
   output logic              mem_valid,
   output logic              mem_rw,
   output logic [7:0]        mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RD_RSP,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          cur_q, cur_d;
   logic [LEN_W-1:0]    count_q, count_d;
   logic                err_q, err_d;
   logic                mem_valid_q, mem_valid_d;
   logic                mem_rw_q, mem_rw_d;
   logic [7:0]          mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_din_q, mem_din_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;

   logic [7:0]          cur_inc;
   logic                cur_oor;
   logic                cmd_oor;
   logic                inc_oor;

   // True when a word address lies outside the attached memory.
   function automatic logic out_of_range(input logic [7:0] a);
      return 32'(a) >= 32'(MEM_DEPTH);
   endfunction

   assign cur_inc = cur_q + 8'd1;
   assign cur_oor = out_of_range(cur_q);
   assign cmd_oor = out_of_range(cmd_addr);
   assign inc_oor = out_of_range(cur_inc);

   // State and datapath registers; asynchronous reset discards any burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         count_q     <= count_d;
         err_q       <= err_d;
         mem_valid_q <= mem_valid_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next-state and next-register logic. The memory strobe is registered, so a
   // read is launched on the transition into RD_ISSUE to be seen during it.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      count_d     = count_q;
      err_d       = err_q;
      mem_valid_d = 1'b0;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               cur_d   = cmd_addr;
               count_d = cmd_len;
               err_d   = 1'b0;
               if (cmd_rw) begin
                  state_d = S_WR_DATA;
               end else begin
                  state_d = S_RD_ISSUE;
                  if (!cmd_oor) begin
                     mem_valid_d = 1'b1;
                     mem_rw_d    = 1'b0;
                     mem_addr_d  = cmd_addr;
                  end
               end
            end
         end

         S_WR_DATA: begin
            if (wdata_valid) begin
               if (cur_oor) begin
                  err_d = 1'b1;
               end else begin
                  mem_valid_d = 1'b1;
                  mem_rw_d    = 1'b1;
                  mem_addr_d  = cur_q;
                  mem_din_d   = wdata;
               end
               cur_d = cur_inc;
               if (count_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
         end

         S_RD_ISSUE: begin
            if (cur_oor) begin
               err_d = 1'b1;
            end
            state_d = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            rsp_err_d  = cur_oor;
            rsp_data_d = cur_oor ? '0 : mem_dout;
            state_d    = S_RD_RSP;
         end

         S_RD_RSP: begin
            if (rsp_ready) begin
               cur_d = cur_inc;
               if (count_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  count_d = count_q - 1'b1;
                  state_d = S_RD_ISSUE;
                  if (!inc_oor) begin
                     mem_valid_d = 1'b1;
                     mem_rw_d    = 1'b0;
                     mem_addr_d  = cur_inc;
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign wdata_ready = (state_q == S_WR_DATA);
   assign rsp_valid   = (state_q == S_RD_RSP);
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign done        = (state_q == S_DONE);
   assign err         = (state_q == S_DONE) && err_q;
   assign mem_valid   = mem_valid_q;
   assign mem_rw      = mem_rw_q;
   assign mem_addr    = mem_addr_q;
   assign mem_din     = mem_din_q;

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Testbench for mem_burst_initiator: behavioural memory, burst-level reference
// model, directed steps followed by randomized bursts.
module tb_mem_burst_initiator;

   localparam int DATA_W    = 32;
   localparam int MEM_DEPTH = 8;
   localparam int LEN_W     = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_rw = 1'b0;
   logic [7:0]        cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              wdata_valid = 1'b0;
   logic              wdata_ready;
   logic [DATA_W-1:0] wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              done;
   logic              err;
   logic              mem_valid;
   logic              mem_rw;
   logic [7:0]        mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout = '0;

   mem_burst_initiator #(
      .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .done(done), .err(err),
      .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port memory; out-of-range accesses are ignored.
   logic [DATA_W-1:0] tb_mem [0:255];
   always @(posedge clk) begin
      if (mem_valid && (32'(mem_addr) < MEM_DEPTH)) begin
         if (mem_rw) tb_mem[mem_addr] <= mem_din;
         else        mem_dout <= tb_mem[mem_addr];
      end
   end

   // Monitor of memory transactions, done pulses and command acceptances.
   logic [63:0] mon_q [$];
   int done_cnt = 0;
   int acc_cnt  = 0;
   always @(negedge clk) begin
      if (mem_valid) mon_q.push_back({23'd0, mem_rw, mem_addr, (mem_rw ? mem_din : 32'd0)});
      if (done) done_cnt++;
      if (cmd_valid && cmd_ready) acc_cnt++;
   end

   // Reference model: memory contents as a burst-level array.
   logic [DATA_W-1:0] ref_mem [0:255];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_queue(input string tag, input logic [63:0] exp_q [$]);
      chk({tag, "_mem_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
         chk({tag, "_mem_txn"}, mon_q[i], exp_q[i]);
      mon_q.delete();
   endtask

   // Write burst: data is base+i, or random when rnd is set.
   task automatic do_write(input logic [7:0] a, input int len, input logic [31:0] base,
                           input bit rnd, input int bubble_pct);
      logic [63:0] exp_q [$];
      logic [31:0] d;
      logic [7:0]  ad;
      bit          exp_err = 0;
      mon_q.delete();
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = a; cmd_len = LEN_W'(len);
      chk("wr_cmd_ready_idle", 64'(cmd_ready), 64'd1);
      step();
      cmd_valid = 1'b0;
      chk("wr_cmd_ready_busy", 64'(cmd_ready), 64'd0);
      for (int i = 0; i <= len; i++) begin
         if (int'($urandom_range(99)) < bubble_pct) step();
         chk("wr_wdata_ready", 64'(wdata_ready), 64'd1);
         d  = rnd ? $urandom : base + 32'(i);
         ad = a + 8'(i);
         if (32'(ad) < MEM_DEPTH) begin
            exp_q.push_back({23'd0, 1'b1, ad, d});
            ref_mem[ad] = d;
         end else begin
            exp_err = 1;
         end
         wdata_valid = 1'b1; wdata = d;
         step();
         wdata_valid = 1'b0;
      end
      chk("wr_done", 64'(done), 64'd1);
      chk("wr_err", 64'(err), 64'(exp_err));
      chk("wr_done_cmd_ready", 64'(cmd_ready), 64'd0);
      step();
      chk("wr_done_clear", 64'(done), 64'd0);
      cmp_queue("wr", exp_q);
      $display("write addr=%0d len=%0d err=%0d", a, len, exp_err);
   endtask

   // Read burst: stall < 0 means random 0..3 cycles of backpressure per beat.
   task automatic do_read(input logic [7:0] a, input int len, input int stall, input bit hold_cmd);
      logic [63:0] exp_q [$];
      logic [7:0]  ad;
      logic [31:0] exp_d, d0;
      logic        e0;
      bit          in_rng;
      bit          exp_err = 0;
      int          waited, k, qs;
      mon_q.delete();
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = a; cmd_len = LEN_W'(len);
      chk("rd_cmd_ready_idle", 64'(cmd_ready), 64'd1);
      step();
      if (!hold_cmd) cmd_valid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         ad     = a + 8'(i);
         in_rng = (32'(ad) < MEM_DEPTH);
         exp_d  = in_rng ? ref_mem[ad] : 32'd0;
         if (in_rng) exp_q.push_back({23'd0, 1'b0, ad, 32'd0});
         else        exp_err = 1;
         waited = 0;
         while (!rsp_valid && waited < 10) begin
            chk("rd_cmd_ready_busy", 64'(cmd_ready), 64'd0);
            step();
            waited++;
         end
         chk("rd_latency", 64'(waited), 64'd2);
         chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
         if (!rsp_valid) return;
         k  = (stall < 0) ? int'($urandom_range(3)) : stall;
         d0 = rsp_data; e0 = rsp_err; qs = mon_q.size();
         rsp_ready = 1'b0;
         for (int s = 0; s < k; s++) step();
         if (k > 0) begin
            chk("rd_stall_valid", 64'(rsp_valid), 64'd1);
            chk("rd_stall_data", 64'(rsp_data), 64'(d0));
            chk("rd_stall_err", 64'(rsp_err), 64'(e0));
            chk("rd_stall_no_issue", 64'(mon_q.size()), 64'(qs));
         end
         chk("rd_data", 64'(rsp_data), 64'(exp_d));
         chk("rd_rsp_err", 64'(rsp_err), 64'(!in_rng));
         $display("read beat addr=%0d data=%h err=%0d stall=%0d", ad, rsp_data, rsp_err, k);
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
      end
      chk("rd_done", 64'(done), 64'd1);
      chk("rd_err", 64'(err), 64'(exp_err));
      chk("rd_done_cmd_ready", 64'(cmd_ready), 64'd0);
      step();
      chk("rd_done_clear", 64'(done), 64'd0);
      cmp_queue("rd", exp_q);
      $display("read addr=%0d len=%0d err=%0d", a, len, exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, a0;
      for (int i = 0; i < 256; i++) begin tb_mem[i] = '0; ref_mem[i] = '0; end

      // Reset state
      reset = 1'b1;
      step(); step();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_outputs", {58'd0, wdata_ready, rsp_valid, done, err, rsp_err, mem_rw}, 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      reset = 1'b0;
      step();

      // Single write, then full-range burst write and read back
      do_write(8'd3, 0, 32'hDEADBEEF, 0, 0);
      do_write(8'd0, 7, 32'h10, 0, 0);
      do_read(8'd0, 7, 0, 0);

      // Read crossing the end of memory
      do_read(8'd6, 3, 0, 0);

      // Backpressure: response held for 5 cycles
      do_read(8'd2, 1, 5, 0);

      // Reset during the third beat of a write
      mon_q.delete();
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'd0; cmd_len = LEN_W'(7);
      step();
      cmd_valid = 1'b0;
      wdata_valid = 1'b1; wdata = 32'hA0; step();
      wdata = 32'hA1; step();
      wdata = 32'hA2; step();
      d0 = done_cnt;
      reset = 1'b1;
      #1;
      wdata_valid = 1'b0;
      chk("midrst_mem_valid", 64'(mem_valid), 64'd0);
      chk("midrst_wdata_ready", 64'(wdata_ready), 64'd0);
      chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
      chk("midrst_mem_din", 64'(mem_din), 64'd0);
      chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      step(); step();
      reset = 1'b0;
      step();
      chk("midrst_no_done", 64'(done_cnt), 64'(d0));
      chk("midrst_writes", 64'(mon_q.size()), 64'd2);
      mon_q.delete();
      ref_mem[0] = 32'hA0; ref_mem[1] = 32'hA1;
      $display("reset during write burst applied");
      do_read(8'd0, 2, 0, 0);

      // cmd_valid held high: one acceptance per IDLE visit
      a0 = acc_cnt;
      do_read(8'd4, 1, 0, 1);
      chk("hold_accept_1", 64'(acc_cnt - a0), 64'd1);
      do_read(8'd4, 1, 0, 0);
      chk("hold_accept_2", 64'(acc_cnt - a0), 64'd2);

      // Address wrap 255 -> 0
      do_write(8'd254, 3, 32'h0, 1, 0);
      do_read(8'd254, 3, -1, 0);

      // Randomized bursts
      for (int t = 0; t < 12; t++) begin
         if ($urandom_range(1) == 1)
            do_write(8'($urandom_range(11)), int'($urandom_range(5)), 32'h0, 1, 30);
         else
            do_read(8'($urandom_range(11)), int'($urandom_range(5)), -1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
